hazard_ctrl: RTL and testbench

- Parametrised pipeline hazard controller for the pipelined MIPS datapath. Successor to the flush-only hazard logic.
- Resolves control transfers at a configurable stage and generates per-latch enable and flush vectors.
- Detects load-use hazards and inserts a configurable number of bubbles.
- Tracks the instruction/data memory handshake so a completed data access is not reissued while fetch is still waiting.
- Latches halt and keeps saturating stall and flush statistics.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/hazard_ctrl_if.sv | 52 +++++
 rtl/sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline control types for the MIPS datapath.
// PC source select, hazard FSM states and resolve-stage control bundle.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10,
    PC_JR  = 2'b11
  } pc_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    MDONE = 2'b01,
    HALT  = 2'b10
  } hzd_state_t;

  typedef struct packed {
    logic jal;
    logic jreg;
    logic jump;
    logic bne;
    logic beq;
    logic zero;
  } ctl_resolve_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the hazard controller and its environment.
// hzd is the controller view, tb the driving side.
interface hazard_ctrl_if #(
  parameter int NUM_STAGES = 5,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 16
) (
  input logic CLK
);
  logic                  nRST;
  logic                  ihit;
  logic                  dhit;
  logic                  mem_ren;
  logic                  mem_wen;
  logic                  rs_valid;
  logic                  jal;
  logic                  jreg;
  logic                  jump;
  logic                  beq;
  logic                  bne;
  logic                  zero;
  logic [REG_W-1:0]      id_rs;
  logic [REG_W-1:0]      id_rt;
  logic                  ex_memread;
  logic [REG_W-1:0]      ex_wsel;
  logic                  wb_halt;
  logic [NUM_STAGES-2:0] en;
  logic [NUM_STAGES-2:0] flush;
  logic                  pc_en;
  logic [1:0]            pc_sel;
  logic                  dmem_mask;
  logic                  halted;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport hzd (
    input  CLK, nRST, ihit, dhit, mem_ren, mem_wen,
    input  rs_valid, jal, jreg, jump, beq, bne, zero,
    input  id_rs, id_rt, ex_memread, ex_wsel, wb_halt,
    output en, flush, pc_en, pc_sel, dmem_mask, halted,
    output stall_cnt, flush_cnt
  );

  modport tb (
    input  CLK,
    output nRST, ihit, dhit, mem_ren, mem_wen,
    output rs_valid, jal, jreg, jump, beq, bne, zero,
    output id_rs, id_rt, ex_memread, ex_wsel, wb_halt,
    input  en, flush, pc_en, pc_sel, dmem_mask, halted,
    input  stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: control-transfer flush, load-use
// bubbles, split imem/dmem handshake tracking, halt and statistics.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int NUM_STAGES    = 5,
  parameter int RESOLVE_STAGE = 3,
  parameter int LU_BUBBLES    = 1,
  parameter int REG_W         = 5,
  parameter int CNT_W         = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  ihit,
  input  logic                  dhit,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic                  rs_valid,
  input  logic                  jal,
  input  logic                  jreg,
  input  logic                  jump,
  input  logic                  beq,
  input  logic                  bne,
  input  logic                  zero,
  input  logic [REG_W-1:0]      id_rs,
  input  logic [REG_W-1:0]      id_rt,
  input  logic                  ex_memread,
  input  logic [REG_W-1:0]      ex_wsel,
  input  logic                  wb_halt,
  output logic [NUM_STAGES-2:0] en,
  output logic [NUM_STAGES-2:0] flush,
  output logic                  pc_en,
  output logic [1:0]            pc_sel,
  output logic                  dmem_mask,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int NL = NUM_STAGES - 1;
  localparam int LW = (LU_BUBBLES > 1) ? $clog2(LU_BUBBLES) : 1;

  hzd_state_t   state;
  hzd_state_t   state_nx;
  ctl_resolve_t ctl;
  pc_sel_t      sel;
  logic         macc;
  logic         adv;
  logic         taken;
  logic         luh;
  logic         lu_busy;
  logic         stall_inc;
  logic         flush_inc;
  logic [LW-1:0] lu_cnt;
  logic [NL-1:0] tk_flush;

  assign ctl     = {jal, jreg, jump, bne, beq, zero};
  assign macc    = mem_ren | mem_wen;
  assign taken   = rs_valid & (ctl.jump | ctl.jal | ctl.jreg |
                   (ctl.beq & ctl.zero) | (ctl.bne & ~ctl.zero));
  assign luh     = ex_memread & (ex_wsel != '0) &
                   ((ex_wsel == id_rs) | (ex_wsel == id_rt));
  assign lu_busy = (lu_cnt != '0);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:     if (macc && dhit && !ihit) state_nx = MDONE;
      MDONE:   if (ihit) state_nx = RUN;
      HALT:    state_nx = HALT;
      default: state_nx = RUN;
    endcase
    if (wb_halt) state_nx = HALT;
  end

  // adv is gated by nRST so every output drops the moment reset asserts
  always_comb begin
    adv       = 1'b0;
    dmem_mask = 1'b0;
    halted    = 1'b0;
    unique case (state)
      RUN:   adv = nRST & ihit & (~macc | dhit);
      MDONE: begin
        adv       = nRST & ihit;
        dmem_mask = 1'b1;
      end
      HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    tk_flush = '0;
    for (int i = 0; i < NL; i++) begin
      tk_flush[i] = (i < RESOLVE_STAGE);
    end
  end

  always_comb begin
    en    = '0;
    flush = '0;
    pc_en = 1'b0;
    unique case (1'b1)
      adv & taken: begin
        en    = '1;
        flush = tk_flush;
        pc_en = 1'b1;
      end
      adv & ~taken & (luh | lu_busy): begin
        en       = '1;
        en[0]    = 1'b0;
        flush[1] = 1'b1;
      end
      adv & ~taken & ~luh & ~lu_busy: begin
        en    = '1;
        pc_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    sel = PC_SEQ;
    unique case (1'b1)
      nRST & taken & ctl.jreg:
        sel = PC_JR;
      nRST & taken & ~ctl.jreg & (ctl.jump | ctl.jal):
        sel = PC_JMP;
      nRST & taken & ~ctl.jreg & ~(ctl.jump | ctl.jal):
        sel = PC_BR;
      default: ;
    endcase
  end

  assign pc_sel = sel;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lu_cnt <= '0;
    end else if (adv) begin
      if (taken) begin
        lu_cnt <= '0;
      end else if (lu_busy) begin
        lu_cnt <= lu_cnt - 1'b1;
      end else if (luh) begin
        lu_cnt <= LW'(LU_BUBBLES - 1);
      end
    end
  end

  assign stall_inc = (state != HALT) & ~pc_en;
  assign flush_inc = adv & taken;

  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector scoreboard bench for hazard_ctrl.
// Stimulus queues expected outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.NUM_STAGES(5), .REG_W(5), .CNT_W(3)) h (.CLK(clk));

  hazard_ctrl #(
    .NUM_STAGES    (5),
    .RESOLVE_STAGE (3),
    .LU_BUBBLES    (2),
    .REG_W         (5),
    .CNT_W         (3)
  ) dut (
    .CLK        (clk),
    .nRST       (h.nRST),
    .ihit       (h.ihit),
    .dhit       (h.dhit),
    .mem_ren    (h.mem_ren),
    .mem_wen    (h.mem_wen),
    .rs_valid   (h.rs_valid),
    .jal        (h.jal),
    .jreg       (h.jreg),
    .jump       (h.jump),
    .beq        (h.beq),
    .bne        (h.bne),
    .zero       (h.zero),
    .id_rs      (h.id_rs),
    .id_rt      (h.id_rt),
    .ex_memread (h.ex_memread),
    .ex_wsel    (h.ex_wsel),
    .wb_halt    (h.wb_halt),
    .en         (h.en),
    .flush      (h.flush),
    .pc_en      (h.pc_en),
    .pc_sel     (h.pc_sel),
    .dmem_mask  (h.dmem_mask),
    .halted     (h.halted),
    .stall_cnt  (h.stall_cnt),
    .flush_cnt  (h.flush_cnt)
  );

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] fl;
    logic       pe;
    logic [1:0] sel;
    logic       msk;
    logic       hlt;
    logic [2:0] sc;
    logic [2:0] fc;
  } obs_t;

  obs_t q[$];
  int   qid[$];
  int   vid = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  obs_t me;
  obs_t ma;
  int   mid;

  function automatic obs_t mk(
    input logic [3:0] en, input logic [3:0] fl, input logic pe,
    input logic [1:0] sel, input logic msk, input logic hlt,
    input logic [2:0] sc, input logic [2:0] fc);
    return '{en:en, fl:fl, pe:pe, sel:sel, msk:msk,
             hlt:hlt, sc:sc, fc:fc};
  endfunction

  task automatic push(input obs_t e);
    q.push_back(e);
    qid.push_back(vid);
    vid++;
  endtask

  task automatic clr();
    h.ihit = 0; h.dhit = 0; h.mem_ren = 0; h.mem_wen = 0;
    h.rs_valid = 0; h.jal = 0; h.jreg = 0; h.jump = 0;
    h.beq = 0; h.bne = 0; h.zero = 0;
    h.id_rs = 0; h.id_rt = 0; h.ex_memread = 0;
    h.ex_wsel = 0; h.wb_halt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    h.nRST = 1'b1;
    clr();
  endtask

  task automatic do_reset();
    tick();
    h.nRST = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me  = q.pop_front();
      mid = qid.pop_front();
      ma  = '{en:h.en, fl:h.flush, pe:h.pc_en, sel:h.pc_sel,
              msk:h.dmem_mask, hlt:h.halted,
              sc:h.stall_cnt, fc:h.flush_cnt};
      n_vec++;
      if (ma !== me) begin
        n_miss++;
        $display("FAIL vec%0d got en=%b fl=%b pe=%b sel=%b msk=%b hlt=%b sc=%0d fc=%0d want en=%b fl=%b pe=%b sel=%b msk=%b hlt=%b sc=%0d fc=%0d",
          mid, ma.en, ma.fl, ma.pe, ma.sel, ma.msk, ma.hlt, ma.sc, ma.fc,
          me.en, me.fl, me.pe, me.sel, me.msk, me.hlt, me.sc, me.fc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    h.nRST = 1'b0;
    clr();

    // reset holds everything low even with a taken jump present
    tick(); h.nRST = 0; h.ihit = 1; h.rs_valid = 1; h.jump = 1;
    push(mk(4'b0000, 4'b0000, 0, 2'b00, 0, 0, 0, 0));

    // branch / jump resolution
    do_reset();
    tick(); h.ihit = 1; h.rs_valid = 1; h.beq = 1; h.zero = 1;
    push(mk(4'b1111, 4'b0111, 1, 2'b01, 0, 0, 0, 0));
    tick(); h.ihit = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 0, 1));
    tick(); h.ihit = 1; h.rs_valid = 1; h.bne = 1; h.zero = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 0, 1));
    tick(); h.ihit = 1; h.rs_valid = 1; h.bne = 1;
    push(mk(4'b1111, 4'b0111, 1, 2'b01, 0, 0, 0, 1));
    tick(); h.ihit = 1; h.jump = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 0, 2));
    tick(); h.ihit = 1; h.rs_valid = 1; h.jump = 1;
    push(mk(4'b1111, 4'b0111, 1, 2'b10, 0, 0, 0, 2));
    tick(); h.ihit = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 0, 3));

    // load-use, two bubbles each
    do_reset();
    tick(); h.ihit = 1; h.ex_memread = 1; h.ex_wsel = 8;
    h.id_rt = 8; h.id_rs = 3;
    push(mk(4'b1110, 4'b0010, 0, 2'b00, 0, 0, 0, 0));
    tick(); h.ihit = 1;
    push(mk(4'b1110, 4'b0010, 0, 2'b00, 0, 0, 1, 0));
    tick(); h.ihit = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 2, 0));
    tick(); h.ihit = 1; h.ex_memread = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 2, 0));
    tick(); h.ihit = 1; h.ex_memread = 1; h.ex_wsel = 5; h.id_rs = 5;
    push(mk(4'b1110, 4'b0010, 0, 2'b00, 0, 0, 2, 0));
    tick(); h.ihit = 1;
    push(mk(4'b1110, 4'b0010, 0, 2'b00, 0, 0, 3, 0));
    tick(); h.ihit = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 4, 0));
    tick(); h.ihit = 1; h.ex_wsel = 5; h.id_rs = 5;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 4, 0));
    tick(); h.ihit = 1; h.ex_memread = 1; h.ex_wsel = 9; h.id_rt = 9;
    push(mk(4'b1110, 4'b0010, 0, 2'b00, 0, 0, 4, 0));
    tick();
    push(mk(4'b0000, 4'b0000, 0, 2'b00, 0, 0, 5, 0));
    tick(); h.ihit = 1;
    push(mk(4'b1110, 4'b0010, 0, 2'b00, 0, 0, 6, 0));
    tick(); h.ihit = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 7, 0));
    tick(); h.ihit = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 7, 0));

    // jreg beats jump, taken beats load-use
    do_reset();
    tick(); h.ihit = 1; h.rs_valid = 1; h.jreg = 1; h.jump = 1;
    h.ex_memread = 1; h.ex_wsel = 8; h.id_rs = 8;
    push(mk(4'b1111, 4'b0111, 1, 2'b11, 0, 0, 0, 0));
    tick(); h.ihit = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 0, 1));
    tick(); h.ihit = 1; h.rs_valid = 1; h.jal = 1; h.beq = 1; h.zero = 1;
    push(mk(4'b1111, 4'b0111, 1, 2'b10, 0, 0, 0, 1));
    tick(); h.ihit = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 0, 2));

    // split memory handshake, then reset while in MDONE
    do_reset();
    tick(); h.mem_ren = 1; h.dhit = 1;
    push(mk(4'b0000, 4'b0000, 0, 2'b00, 0, 0, 0, 0));
    tick(); h.mem_ren = 1;
    push(mk(4'b0000, 4'b0000, 0, 2'b00, 1, 0, 1, 0));
    tick(); h.ihit = 1; h.mem_ren = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 1, 0, 2, 0));
    tick(); h.ihit = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 2, 0));
    tick(); h.ihit = 1; h.mem_wen = 1;
    push(mk(4'b0000, 4'b0000, 0, 2'b00, 0, 0, 2, 0));
    tick(); h.ihit = 1; h.mem_wen = 1; h.dhit = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 3, 0));
    tick(); h.mem_ren = 1; h.dhit = 1;
    push(mk(4'b0000, 4'b0000, 0, 2'b00, 0, 0, 3, 0));
    tick();
    push(mk(4'b0000, 4'b0000, 0, 2'b00, 1, 0, 4, 0));
    tick(); h.nRST = 0;
    push(mk(4'b0000, 4'b0000, 0, 2'b00, 0, 0, 0, 0));
    tick(); h.ihit = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 0, 0));

    // halt is sticky until reset
    do_reset();
    tick(); h.ihit = 1; h.wb_halt = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      tick(); h.ihit = 1;
      push(mk(4'b0000, 4'b0000, 0, 2'b00, 0, 1, 0, 0));
    end
    tick(); h.nRST = 0; h.ihit = 1;
    push(mk(4'b0000, 4'b0000, 0, 2'b00, 0, 0, 0, 0));
    tick(); h.ihit = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 0, 0));

    // stall counter saturates at 7
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      push(mk(4'b0000, 4'b0000, 0, 2'b00, 0, 0,
              3'((i > 7) ? 7 : i), 0));
    end
    tick(); h.ihit = 1;
    push(mk(4'b1111, 4'b0000, 1, 2'b00, 0, 0, 7, 0));

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
